pump_power_arbiter: RTL
=======================

Name: pump_power_arbiter

Overview:
Shares a single pump power feed between the two tank pumps, B1 (well→lower tank) and B2 (lower→upper tank). Per-pump request lines come from the tank level FSMs. The block drives the actual pump enables with three guarantees: mutual exclusion, minimum on-time, and a dead time between switchovers. It also detects a stuck-on or dry-run condition by timeout and latches a fault until software/operator clear.

Parameters:
MIN_ON, 8, minimum cycles a granted pump stays on
DEAD_TIME, 4, cycles with both pumps off after any release
MAX_ON, 64, max continuous on-cycles while still requested before fault
QUANTUM, 16, preemption slice in cycles (used only with PUMP_PREEMPT_EN)
CNT_W, 8, counter width; must hold MAX_ON and DEAD_TIME

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Req1  input  1  pump B1 run request from tank-1 level logic
Req2  input  1  pump B2 run request from tank-2 level logic
ClearFault  input  1  single-cycle pulse, leaves FAULT
Grant1  output  1  drive for pump B1 (registered)
Grant2  output  1  drive for pump B2 (registered)
Fault  output  1  latched timeout fault
FaultSrc  output  2  01 = B1 timed out, 10 = B2 timed out, 00 = none
Busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: Clock is the clock. Reset is the reset: asynchronous, active-low.
- Reset (async, any state):
  - State=IDLE, Grant1=Grant2=0, Fault=0, FaultSrc=00, Busy=0, cnt=0.
  - Last=2, so pump 1 wins the first tie.
- States: IDLE, RUN1, RUN2, DEAD, FAULT. All outputs decode from registered state, so latency from Req to Grant is 1 cycle.
- IDLE:
  - Req1 & Req2 → grant the pump ≠ Last.
  - Only Req1 → RUN1. Only Req2 → RUN2.
  - cnt cleared on entry to RUNx.
- RUNx:
  - Grantx=1. cnt increments each cycle, saturating.
  - Release: if !Reqx and cnt ≥ MIN_ON-1 → DEAD; Last=x. A request dropped early keeps the pump on until MIN_ON cycles are complete.
  - Timeout: if Reqx and cnt == MAX_ON-1 → FAULT, FaultSrc=x. Pump was on exactly MAX_ON cycles.
  - Release has priority over timeout in the same cycle.
- DEAD:
  - Both grants 0. Count DEAD_TIME cycles, then → IDLE.
  - Requests arriving during DEAD are held off, not lost; they are sampled in IDLE.
- FAULT:
  - Both grants 0, Fault=1. Requests ignored.
  - ClearFault=1 → DEAD, with Fault/FaultSrc cleared on the same edge. Dead time is always honoured after a fault.
- Invariant: Grant1 & Grant2 is never 1, including across reset release.
- ClearFault outside FAULT: ignored.
- Counter saturates at 2^CNT_W-1; never wraps.

Optional Feature:
PUMP_PREEMPT_EN
- Defined: in RUNx, if the other Req is high and cnt ≥ QUANTUM-1 (QUANTUM ≥ MIN_ON), release to DEAD with Last=x, regardless of Reqx. The fault timeout still applies but is unreachable when QUANTUM < MAX_ON and the other pump is waiting.
- Undefined: no preemption; a pump runs until release or MAX_ON. QUANTUM is unused.

Test Plan:
1. Req1 pulsed 1 cycle at T → Grant1=1 cycles T+1..T+8, both 0 for T+9..T+12, Busy=0 at T+13.
2. Req1 and Req2 both high from reset release; Req1 drops after 10 grant cycles → Grant1 10 cycles, 4 dead, then Grant2=1; Grant1 & Grant2 never both 1.
3. Req1 held high 100 cycles → Grant1 high 64 cycles, then Fault=1, FaultSrc=01, grants 0. ClearFault pulse → Fault=0, 4 dead cycles, Grant1=1 again.
4. Reset driven low mid-RUN2 (asynchronous to Clock) → Grant2=0 immediately, Busy=0. Reset released with Req2=1 → Grant2=1 one cycle after the first clock edge.
5. PUMP_PREEMPT_EN defined, both Req held → Grant1 16, dead 4, Grant2 16, dead 4, repeating; Fault stays 0. Without the macro: Grant1 64, then Fault=1, FaultSrc=01.
6. Req2 asserted during DEAD after a B1 release → Grant2 rises exactly 1 cycle after DEAD ends (IDLE for 1 cycle).

Source files
------------

// File: rtl/pump_power_arbiter.sv
// Pump power arbiter: one supply feed is shared between pumps B1 and B2, with
// mutual exclusion, a minimum on-time, dead time between pumps and a latched
// timeout fault. Define PUMP_PREEMPT_EN to enable quantum-based preemption.
//
// state | meaning
// IDLE  | both pumps off, sampling requests
// RUN1  | pump B1 granted
// RUN2  | pump B2 granted
// DEAD  | both pumps off for DEAD_TIME cycles after a release or a fault clear
// FAULT | timeout latched, waiting for ClearFault
module pump_power_arbiter #(
  parameter int unsigned MIN_ON    = 8,
  parameter int unsigned DEAD_TIME = 4,
  parameter int unsigned MAX_ON    = 64,
  parameter int unsigned QUANTUM   = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req1,
  input  logic       Req2,
  input  logic       ClearFault,
  output logic       Grant1,
  output logic       Grant2,
  output logic       Fault,
  output logic [1:0] FaultSrc,
  output logic       Busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN1  = 3'd1,
    RUN2  = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MIN_ON_TC  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] MAX_ON_TC  = CNT_W'(MAX_ON - 1);
  localparam logic [CNT_W-1:0] DEAD_TC    = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
`ifdef PUMP_PREEMPT_EN
  localparam logic [CNT_W-1:0] QUANTUM_TC = CNT_W'(QUANTUM - 1);
`endif

  // Bad parameter sets are rejected at elaboration rather than misbehaving.
  if (QUANTUM < MIN_ON || MIN_ON < 1 || DEAD_TIME < 1 ||
      MAX_ON < MIN_ON || MAX_ON > (2 ** CNT_W) || DEAD_TIME > (2 ** CNT_W)) begin : g_param_check
    $error("pump_power_arbiter: inconsistent timing parameters");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             last_b2, last_b2_nxt;
  logic [1:0]       src, src_nxt;
  logic             run_req;
`ifdef PUMP_PREEMPT_EN
  logic             oth_req;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last_b2 <= 1'b1;
      src     <= 2'b00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last_b2 <= last_b2_nxt;
      src     <= src_nxt;
    end
  end

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
  assign run_req = (state == RUN1) ? Req1 : Req2;
`ifdef PUMP_PREEMPT_EN
  assign oth_req = (state == RUN1) ? Req2 : Req1;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_b2_nxt = last_b2;
    src_nxt     = src;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (Req1 && Req2)
          state_nxt = last_b2 ? RUN1 : RUN2;
        else if (Req1)
          state_nxt = RUN1;
        else if (Req2)
          state_nxt = RUN2;
      end
      RUN1, RUN2: begin
        cnt_nxt = cnt_inc;
        // Release outranks the timeout when both fall on the same cycle.
        if (!run_req && cnt >= MIN_ON_TC) begin
          state_nxt   = DEAD;
          cnt_nxt     = '0;
          last_b2_nxt = (state == RUN2);
        end
`ifdef PUMP_PREEMPT_EN
        else if (oth_req && cnt >= QUANTUM_TC) begin
          state_nxt   = DEAD;
          cnt_nxt     = '0;
          last_b2_nxt = (state == RUN2);
        end
`endif
        else if (run_req && cnt == MAX_ON_TC) begin
          state_nxt = FAULT;
          cnt_nxt   = '0;
          src_nxt   = (state == RUN1) ? 2'b01 : 2'b10;
        end
      end
      DEAD: begin
        cnt_nxt = cnt_inc;
        if (cnt >= DEAD_TC) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      FAULT: begin
        if (ClearFault) begin
          state_nxt = DEAD;
          cnt_nxt   = '0;
          src_nxt   = 2'b00;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Every output decodes from the state register, so the grants can never overlap.
  assign Grant1   = (state == RUN1);
  assign Grant2   = (state == RUN2);
  assign Fault    = (state == FAULT);
  assign FaultSrc = src;
  assign Busy     = (state != IDLE);

endmodule
